// File: rtl/cpc_bank_ctrl_if.sv
// Z80-side bus and expansion-RAM mapping signals of the CPC bank controller.
// master = CPU/bench side, slave = controller side.
interface cpc_bank_ctrl_if #(
    parameter int BANK_BITS = 3
);
    // Z80 strobes are active-low levels; a config write is a level held across
    // clocks, captured on the first sample and committed when it goes away.
    logic [2:0]           adr;
    logic [7:0]           data;
    logic                 iorqb;
    logic                 wrb;
    logic                 m1b;
    logic                 mreqb;
    logic                 ramdis;
    logic                 ext_ceb;
    logic [BANK_BITS+1:0] ext_adr;
    logic [1:0]           int_remap;
    logic [5:0]           cfg;
    logic                 dbg_state;

    modport master (
        output adr, data, iorqb, wrb, m1b, mreqb,
        input  ramdis, ext_ceb, ext_adr, int_remap, cfg, dbg_state
    );

    modport slave (
        input  adr, data, iorqb, wrb, m1b, mreqb,
        output ramdis, ext_ceb, ext_adr, int_remap, cfg, dbg_state
    );
endinterface

// File: rtl/cpc_bank_ctrl.sv
// CPC RAM expansion memory-config controller: captures gate-array config
// writes into a 6-bit register and maps each memory access to internal/ext RAM.
module cpc_bank_ctrl #(
    parameter int BANK_BITS = 3,
    parameter bit MODE3_EN  = 1'b1
) (
    input  logic           clock,
    input  logic           resetb,
    cpc_bank_ctrl_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, CAPT = 1'b1} state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic   [5:0]   r_shadow;
    logic   [5:0]   r_cfg;
    logic           w_match;
    logic           w_load;
    logic           w_commit;
    logic   [5:0]   w_cfg_new;

    assign w_match = !bus.iorqb && !bus.wrb && bus.m1b && !bus.adr[2]
                     && (bus.data[7:6] == 2'b11);

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_match) begin
                    w_load       = 1'b1;
                    w_state_next = CAPT;
                end
            end
            CAPT: begin
                if (bus.iorqb || bus.wrb) begin
                    w_commit     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Bank bits above BANK_BITS are never stored.
    always_comb begin
        w_cfg_new                   = '0;
        w_cfg_new[2:0]              = r_shadow[2:0];
        w_cfg_new[3 +: BANK_BITS]   = r_shadow[3 +: BANK_BITS];
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state  <= IDLE;
            r_shadow <= '0;
            r_cfg    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load)
                r_shadow <= bus.data[5:0];
            if (w_commit)
                r_cfg <= w_cfg_new;
        end
    end

    logic [2:0]           w_mode;
    logic [BANK_BITS-1:0] w_bank;
    logic [1:0]           w_blk;
    logic                 w_ext;
    logic [1:0]           w_page;
    logic [1:0]           w_remap;

    assign w_mode = r_cfg[2:0];
    assign w_bank = r_cfg[3 +: BANK_BITS];
    assign w_blk  = bus.adr[1:0];

    always_comb begin
        w_ext   = 1'b0;
        w_page  = 2'b00;
        w_remap = w_blk;
        case (w_mode)
            3'd1: begin
                if (w_blk == 2'd3) begin
                    w_ext  = 1'b1;
                    w_page = 2'd3;
                end
            end
            3'd2: begin
                w_ext  = 1'b1;
                w_page = w_blk;
            end
            3'd3: begin
                // Without mode-3 support this config behaves exactly like mode 0.
                if (MODE3_EN) begin
                    if (w_blk == 2'd3) begin
                        w_ext  = 1'b1;
                        w_page = 2'd3;
                    end else if (w_blk == 2'd1) begin
                        w_remap = 2'b11;
                    end
                end
            end
            default: begin
                if (w_mode[2] && (w_blk == 2'd1)) begin
                    w_ext  = 1'b1;
                    w_page = w_mode[1:0];
                end
            end
        endcase
    end

    assign bus.ramdis    = w_ext;
    assign bus.ext_ceb   = w_ext ? bus.mreqb : 1'b1;
    assign bus.ext_adr   = w_ext ? {w_bank, w_page} : '0;
    assign bus.int_remap = w_remap;
    assign bus.cfg       = r_cfg;
    assign bus.dbg_state = (r_state == CAPT);
endmodule
